shot_resolver: RTL

Resolves each player shot against the current target and drives the target generator. Accepts a fire request, launches a projectile at the player column, and steps it up the 32-row field. When the projectile reaches the target row it issues a one-cycle `result_valid` with hit/miss, updates score and lives, and returns to idle. Its `shoot` and `result_valid` outputs feed the target generator's advance inputs directly; the target generator's `target_x`/`target_y` feed back in.

---
 rtl/game_pkg.sv | 24 ++
 rtl/shot_step_timer.sv | 32 +++
 rtl/shot_resolver.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the shot/target game blocks: default widths,
// the shot FSM state encoding and the life-counter helper.
package game_pkg;

    localparam int COORD_W_DEF = 5;
    localparam int SCORE_W_DEF = 8;
    localparam int LIVES_DEF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLY     = 2'd1,
        ST_RESOLVE = 2'd2
    } shot_state_e;

    // Lives never wrap below zero, even if a miss arrives with none left.
    function automatic logic [2:0] lives_dec(input logic [2:0] lives_in);
        if (lives_in == 3'd0) begin
            return 3'd0;
        end else begin
            return lives_in - 3'd1;
        end
    endfunction

endpackage

// File: rtl/shot_step_timer.sv
// Row-advance timer: counts clock cycles while running and flags the last
// cycle of each STEP_CYCLES-long row period.
module shot_step_timer
    import game_pkg::*;
#(
    parameter int STEP_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;

    assign tick = (cnt_r == LAST);

    // Cycle counter, restarted on clear and on every row boundary.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear || tick) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/shot_resolver.sv
// Launches a projectile at the player column, walks it up the field and
// resolves it against the live target, keeping score, lives and game-over.
module shot_resolver
    import game_pkg::*;
#(
    parameter int COORD_W     = COORD_W_DEF,
    parameter int STEP_CYCLES = 4,
    parameter int SCORE_W     = SCORE_W_DEF,
    parameter int LIVES       = LIVES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fire,
    input  logic [COORD_W-1:0] player_x,
    input  logic [COORD_W-1:0] target_x,
    input  logic [COORD_W-1:0] target_y,
    output logic               shoot,
    output logic               shot_active,
    output logic [COORD_W-1:0] shot_x,
    output logic [COORD_W-1:0] shot_y,
    output logic               result_valid,
    output logic               hit,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         lives,
    output logic               game_over
);

    localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
    localparam logic [COORD_W-1:0] Y_TOP      = {COORD_W{1'b1}};
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

    shot_state_e        state_r, state_s;
    logic               shoot_r, shoot_s;
    logic               active_r, active_s;
    logic [COORD_W-1:0] shot_x_r, shot_x_s;
    logic [COORD_W-1:0] shot_y_r, shot_y_s;
    logic               rv_r, rv_s;
    logic               hit_r, hit_s;
    logic [SCORE_W-1:0] score_r, score_s;
    logic [2:0]         lives_r, lives_s;
    logic               go_r, go_s;
    logic               tick_s;
    logic               timer_clear_s;

    // The timer only runs in flight, so each launch starts a fresh row period.
    assign timer_clear_s = (state_r != ST_FLY);

    shot_step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear_s),
        .tick  (tick_s)
    );

    // Next-state and next-output logic; every output is computed one cycle early.
    always_comb begin
        state_s  = state_r;
        shoot_s  = 1'b0;
        active_s = 1'b0;
        shot_x_s = shot_x_r;
        shot_y_s = shot_y_r;
        rv_s     = 1'b0;
        hit_s    = hit_r;
        score_s  = score_r;
        lives_s  = lives_r;
        go_s     = go_r;
        case (state_r)
            ST_IDLE: begin
                if (fire && !go_r) begin
                    state_s  = ST_FLY;
                    shoot_s  = 1'b1;
                    active_s = 1'b1;
                    shot_x_s = player_x;
                    shot_y_s = {COORD_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FLY: begin
                active_s = 1'b1;
                if (tick_s && ((shot_y_r == target_y) || (shot_y_r == Y_TOP))) begin
                    // Target row wins over the field edge when both coincide.
                    state_s  = ST_RESOLVE;
                    active_s = 1'b0;
                    rv_s     = 1'b1;
                    hit_s    = (shot_y_r == target_y) && (shot_x_r == target_x);
                    if (hit_s) begin
                        if (score_r != SCORE_MAX) begin
                            score_s = score_r + SCORE_W'(1);
                        end else begin
                            score_s = score_r;
                        end
                    end else begin
                        lives_s = lives_dec(lives_r);
                        go_s    = (lives_s == 3'd0);
                    end
                end else if (tick_s) begin
                    shot_y_s = shot_y_r + COORD_W'(1);
                end else begin
                    shot_y_s = shot_y_r;
                end
            end
            ST_RESOLVE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            shoot_r  <= 1'b0;
            active_r <= 1'b0;
            shot_x_r <= {COORD_W{1'b0}};
            shot_y_r <= {COORD_W{1'b0}};
            rv_r     <= 1'b0;
            hit_r    <= 1'b0;
            score_r  <= {SCORE_W{1'b0}};
            lives_r  <= LIVES_INIT;
            go_r     <= 1'b0;
        end else begin
            state_r  <= state_s;
            shoot_r  <= shoot_s;
            active_r <= active_s;
            shot_x_r <= shot_x_s;
            shot_y_r <= shot_y_s;
            rv_r     <= rv_s;
            hit_r    <= hit_s;
            score_r  <= score_s;
            lives_r  <= lives_s;
            go_r     <= go_s;
        end
    end

    assign shoot        = shoot_r;
    assign shot_active  = active_r;
    assign shot_x       = shot_x_r;
    assign shot_y       = shot_y_r;
    assign result_valid = rv_r;
    assign hit          = hit_r;
    assign score        = score_r;
    assign lives        = lives_r;
    assign game_over    = go_r;

endmodule
